// File: rtl/svc_rv_lsu.sv
// svc_rv_lsu: load/store unit between the RV execute stage and a 32-bit data
// memory. One transaction at a time over a valid/ready request channel and an
// rvalid response channel. Misaligned or unknown-width ops complete with err
// and never touch memory. Every result output comes straight from a flop.
module svc_rv_lsu #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            op_valid,
  output logic            op_ready,
  input  logic            op_is_store,
  input  logic [2:0]      op_funct3,
  input  logic [XLEN-1:0] op_addr,
  input  logic [XLEN-1:0] op_wdata,
  output logic            done,
  output logic            err,
  output logic [XLEN-1:0] rdata,
  output logic            dmem_req_valid,
  input  logic            dmem_req_ready,
  output logic            dmem_we,
  output logic [XLEN-1:0] dmem_addr,
  output logic [3:0]      dmem_wstrb,
  output logic [XLEN-1:0] dmem_wdata,
  input  logic            dmem_rvalid,
  input  logic [XLEN-1:0] dmem_rdata
);

  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, RESP = 2'd2} state_t;

  state_t            state, state_next;
  logic              is_store, is_store_next;
  logic [2:0]        funct3, funct3_next;
  logic [1:0]        addr_lo, addr_lo_next;
  logic              done_next, err_next, req_valid_next, we_next;
  logic [XLEN-1:0]   rdata_next, addr_next, wdata_next;
  logic [3:0]        wstrb_next;

  // Width code / alignment legality for an incoming op.
  function automatic logic op_legal(input logic st, input logic [2:0] f3, input logic [1:0] lo);
    logic ok;
    case (f3)
      3'd0:    ok = 1'b1;
      3'd1:    ok = (lo[0] == 1'b0);
      3'd2:    ok = (lo == 2'b00);
      3'd4:    ok = !st;
      3'd5:    ok = !st && (lo[0] == 1'b0);
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

  // Byte enables for a store of the given width at the given lane.
  function automatic logic [3:0] store_strb(input logic [2:0] f3, input logic [1:0] lo);
    logic [3:0] s;
    case (f3[1:0])
      2'd0:    s = 4'b0001 << lo;
      2'd1:    s = 4'b0011 << lo;
      default: s = 4'b1111;
    endcase
    return s;
  endfunction

  // Replicate the store data across all lanes so any strobe picks the right bytes.
  function automatic logic [31:0] store_lanes(input logic [2:0] f3, input logic [31:0] wd);
    logic [31:0] w;
    case (f3[1:0])
      2'd0:    w = {4{wd[7:0]}};
      2'd1:    w = {2{wd[15:0]}};
      default: w = wd;
    endcase
    return w;
  endfunction

  // Select the addressed lane of the read word and sign/zero extend it.
  function automatic logic [31:0] load_extend(input logic [2:0] f3, input logic [1:0] lo,
                                              input logic [31:0] word);
    logic [31:0] shifted;
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    shifted = word >> {lo, 3'b000};
    b = shifted[7:0];
    h = lo[1] ? word[31:16] : word[15:0];
    case (f3)
      3'd0:    r = {{24{b[7]}}, b};
      3'd4:    r = {24'd0, b};
      3'd1:    r = {{16{h[15]}}, h};
      3'd5:    r = {16'd0, h};
      default: r = word;
    endcase
    return r;
  endfunction

  assign op_ready = (state == IDLE) && !rst;

  // Next-state and next-output computation for the transaction FSM.
  always_comb begin
    state_next     = state;
    is_store_next  = is_store;
    funct3_next    = funct3;
    addr_lo_next   = addr_lo;
    done_next      = 1'b0;
    err_next       = 1'b0;
    rdata_next     = rdata;
    req_valid_next = dmem_req_valid;
    we_next        = dmem_we;
    addr_next      = dmem_addr;
    wstrb_next     = dmem_wstrb;
    wdata_next     = dmem_wdata;
    case (state)
      IDLE: begin
        if (op_valid) begin
          is_store_next = op_is_store;
          funct3_next   = op_funct3;
          addr_lo_next  = op_addr[1:0];
          if (op_legal(op_is_store, op_funct3, op_addr[1:0])) begin
            state_next     = REQ;
            req_valid_next = 1'b1;
            we_next        = op_is_store;
            addr_next      = {op_addr[XLEN-1:2], 2'b00};
            wstrb_next     = op_is_store ? store_strb(op_funct3, op_addr[1:0]) : 4'b0000;
            wdata_next     = store_lanes(op_funct3, op_wdata);
          end else begin
            done_next = 1'b1;
            err_next  = 1'b1;
          end
        end else begin
          state_next = IDLE;
        end
      end
      REQ: begin
        if (dmem_req_ready) begin
          req_valid_next = 1'b0;
          we_next        = 1'b0;
          wstrb_next     = 4'b0000;
          if (is_store) begin
            state_next = IDLE;
            done_next  = 1'b1;
          end else begin
            state_next = RESP;
          end
        end else begin
          state_next = REQ;
        end
      end
      RESP: begin
        if (dmem_rvalid) begin
          state_next = IDLE;
          done_next  = 1'b1;
          rdata_next = load_extend(funct3, addr_lo, dmem_rdata);
        end else begin
          state_next = RESP;
        end
      end
      default: begin
        state_next     = IDLE;
        req_valid_next = 1'b0;
        we_next        = 1'b0;
        wstrb_next     = 4'b0000;
      end
    endcase
  end

  // State, latched op context and all registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      is_store       <= 1'b0;
      funct3         <= 3'd0;
      addr_lo        <= 2'd0;
      done           <= 1'b0;
      err            <= 1'b0;
      rdata          <= '0;
      dmem_req_valid <= 1'b0;
      dmem_we        <= 1'b0;
      dmem_addr      <= '0;
      dmem_wstrb     <= 4'b0000;
      dmem_wdata     <= '0;
    end else begin
      state          <= state_next;
      is_store       <= is_store_next;
      funct3         <= funct3_next;
      addr_lo        <= addr_lo_next;
      done           <= done_next;
      err            <= err_next;
      rdata          <= rdata_next;
      dmem_req_valid <= req_valid_next;
      dmem_we        <= we_next;
      dmem_addr      <= addr_next;
      dmem_wstrb     <= wstrb_next;
      dmem_wdata     <= wdata_next;
    end
  end

endmodule

// File: tb/tb_svc_rv_lsu.sv
// tb_svc_rv_lsu: directed plus randomized load/store sequence against a
// byte-addressed reference memory model kept in the bench.
module tb_svc_rv_lsu;

  logic        clk = 1'b0;
  logic        rst;
  logic        op_valid, op_ready, op_is_store;
  logic [2:0]  op_funct3;
  logic [31:0] op_addr, op_wdata;
  logic        done, err;
  logic [31:0] rdata;
  logic        dmem_req_valid, dmem_req_ready, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata;
  logic [3:0]  dmem_wstrb;
  logic        dmem_rvalid;
  logic [31:0] dmem_rdata;

  int n_cmp = 0;
  int n_err = 0;
  logic [7:0] mem_b [0:255];

  svc_rv_lsu #(.XLEN(32)) dut (
    .clk(clk), .rst(rst),
    .op_valid(op_valid), .op_ready(op_ready), .op_is_store(op_is_store),
    .op_funct3(op_funct3), .op_addr(op_addr), .op_wdata(op_wdata),
    .done(done), .err(err), .rdata(rdata),
    .dmem_req_valid(dmem_req_valid), .dmem_req_ready(dmem_req_ready),
    .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wstrb(dmem_wstrb),
    .dmem_wdata(dmem_wdata), .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [7:0] w;
    w = {a[7:2], 2'b00};
    return {mem_b[w + 8'd3], mem_b[w + 8'd2], mem_b[w + 8'd1], mem_b[w]};
  endfunction

  // One complete op: drive, serve memory, compare against the model.
  task automatic do_op(input bit st, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd, input int req_dly, input int rv_dly,
                       input bit rst_resp);
    int          sz, lane;
    bit          legal, sgn;
    logic [3:0]  exp_strb;
    logic [31:0] exp_wd, exp_rd, exp_addr;
    longint      v;
    sz  = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    sgn = (f3[2] == 1'b0);
    legal = st ? (f3 <= 3'd2) : (f3 <= 3'd2 || f3 == 3'd4 || f3 == 3'd5);
    legal = legal && ((a % sz) == 0);
    lane = a % 4;
    exp_addr = a - (a % 4);
    exp_strb = 4'b0000;
    exp_wd = 32'd0;
    for (int i = 0; i < 4; i++) begin
      if (st && i >= lane && i < lane + sz) exp_strb[i] = 1'b1;
      exp_wd[8*i +: 8] = wd[8*(i % sz) +: 8];
    end
    @(negedge clk);
    chk("op_ready_idle", {31'd0, op_ready}, 32'd1);
    op_valid = 1'b1; op_is_store = st; op_funct3 = f3; op_addr = a; op_wdata = wd;
    @(negedge clk);
    op_valid = 1'b0;
    if (!legal) begin
      chk("err_done", {30'd0, done, err}, 32'd3);
      chk("err_no_req", {31'd0, dmem_req_valid}, 32'd0);
      @(negedge clk);
      chk("err_pulse", {30'd0, done, err}, 32'd0);
      chk("err_no_req2", {31'd0, dmem_req_valid}, 32'd0);
      return;
    end
    chk("req_valid", {31'd0, dmem_req_valid}, 32'd1);
    chk("req_addr", dmem_addr, exp_addr);
    chk("req_we", {31'd0, dmem_we}, {31'd0, st});
    chk("req_wstrb", {28'd0, dmem_wstrb}, {28'd0, exp_strb});
    if (st) chk("req_wdata", dmem_wdata, exp_wd);
    for (int i = 0; i < req_dly; i++) begin
      op_valid = 1'b1; op_addr = $urandom; op_funct3 = 3'd2; op_is_store = 1'b1;
      @(negedge clk);
      chk("stall_valid", {31'd0, dmem_req_valid}, 32'd1);
      chk("stall_addr", dmem_addr, exp_addr);
      chk("stall_wstrb", {28'd0, dmem_wstrb}, {28'd0, exp_strb});
      chk("stall_busy", {30'd0, op_ready, done}, 32'd0);
    end
    op_valid = 1'b0;
    dmem_req_ready = 1'b1;
    @(negedge clk);
    dmem_req_ready = 1'b0;
    if (st) begin
      for (int i = 0; i < sz; i++) mem_b[a[7:0] + 8'(i)] = wd[8*i +: 8];
      chk("st_done", {30'd0, done, err}, 32'd2);
      chk("st_req_drop", {31'd0, dmem_req_valid}, 32'd0);
      @(negedge clk);
      chk("st_done_pulse", {31'd0, done}, 32'd0);
      return;
    end
    v = 0;
    for (int i = 0; i < sz; i++) v = v | (longint'(mem_b[a[7:0] + 8'(i)]) << (8 * i));
    if (sgn && v[8*sz-1]) v = v - (longint'(1) << (8 * sz));
    exp_rd = v[31:0];
    chk("ld_req_drop", {31'd0, dmem_req_valid}, 32'd0);
    if (rst_resp) begin
      rst = 1'b1;
      @(negedge clk);
      chk("rst_ready_low", {30'd0, op_ready, dmem_req_valid}, 32'd0);
      rst = 1'b0;
      dmem_rvalid = 1'b1; dmem_rdata = mem_word(a);
      @(negedge clk);
      dmem_rvalid = 1'b0;
      chk("late_rvalid_no_done", {31'd0, done}, 32'd0);
      chk("rst_ready_back", {31'd0, op_ready}, 32'd1);
      @(negedge clk);
      chk("late_rvalid_no_done2", {31'd0, done}, 32'd0);
      return;
    end
    for (int i = 0; i < rv_dly; i++) begin
      op_valid = 1'b1; op_addr = $urandom;
      @(negedge clk);
      chk("resp_wait", {30'd0, op_ready, done}, 32'd0);
    end
    op_valid = 1'b0;
    dmem_rvalid = 1'b1; dmem_rdata = mem_word(a);
    @(negedge clk);
    dmem_rvalid = 1'b0; dmem_rdata = $urandom;
    chk("ld_done", {30'd0, done, err}, 32'd2);
    chk("ld_rdata", rdata, exp_rd);
    chk("ld_ready", {31'd0, op_ready}, 32'd1);
    @(negedge clk);
    chk("ld_done_pulse", {31'd0, done}, 32'd0);
    chk("ld_rdata_hold", rdata, exp_rd);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem_b[i] = 8'h00;
    rst = 1'b1; op_valid = 1'b0; op_is_store = 1'b0; op_funct3 = 3'd0;
    op_addr = 32'd0; op_wdata = 32'd0; dmem_req_ready = 1'b0;
    dmem_rvalid = 1'b0; dmem_rdata = 32'd0;
    repeat (3) @(negedge clk);
    chk("rst_op_ready", {31'd0, op_ready}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_outs", {28'd0, done, err, dmem_req_valid, dmem_we}, 32'd0);
    chk("rst_wstrb", {28'd0, dmem_wstrb}, 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_ready_after", {31'd0, op_ready}, 32'd1);

    // Directed stores
    do_op(1'b1, 3'd2, 32'h100, 32'hDEADBEEF, 0, 0, 1'b0);
    do_op(1'b1, 3'd0, 32'h103, 32'h000000A5, 0, 0, 1'b0);
    do_op(1'b1, 3'd1, 32'h102, 32'h00001234, 1, 0, 1'b0);
    do_op(1'b1, 3'd2, 32'h100, 32'h80FF7F01, 0, 0, 1'b0);
    // Directed loads on 0x80FF7F01
    do_op(1'b0, 3'd0, 32'h101, 32'h0, 0, 0, 1'b0);
    do_op(1'b0, 3'd0, 32'h103, 32'h0, 0, 1, 1'b0);
    do_op(1'b0, 3'd4, 32'h103, 32'h0, 0, 0, 1'b0);
    do_op(1'b0, 3'd1, 32'h102, 32'h0, 0, 0, 1'b0);
    do_op(1'b0, 3'd5, 32'h102, 32'h0, 0, 0, 1'b0);
    do_op(1'b0, 3'd2, 32'h100, 32'h0, 0, 0, 1'b0);
    // Illegal ops
    do_op(1'b0, 3'd2, 32'h102, 32'h0, 0, 0, 1'b0);
    do_op(1'b0, 3'd1, 32'h101, 32'h0, 0, 0, 1'b0);
    do_op(1'b0, 3'd3, 32'h100, 32'h0, 0, 0, 1'b0);
    do_op(1'b1, 3'd4, 32'h100, 32'h0, 0, 0, 1'b0);
    // Long stall on request and response
    do_op(1'b0, 3'd2, 32'h100, 32'h0, 5, 3, 1'b0);
    // Reset while waiting for the response, then a normal load
    do_op(1'b0, 3'd2, 32'h100, 32'h0, 0, 0, 1'b1);
    do_op(1'b0, 3'd2, 32'h100, 32'h0, 0, 0, 1'b0);

    // Randomized mix
    for (int k = 0; k < 60; k++) begin
      do_op(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
            32'h100 + 32'($urandom_range(0, 60)), $urandom,
            $urandom_range(0, 3), $urandom_range(0, 3), 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
